// File: rtl/step_clock_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_clock_gen
// Description : Sequencer step clock. Converts a committed tempo (BPM) into a
//               step period in system clock cycles using a sequential
//               restoring divider, then free-runs a step counter that emits
//               one-cycle step and beat pulses and a 0..15 step index.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk        in   1   system clock, rising edge
//   i_rst        in   1   synchronous active-high reset
//   i_enable     in   1   run (1) / stop (0) of the step playhead
//   i_bpm        in  10   requested tempo, 0..999
//   i_set        in   1   tempo commit flag; a 0->1 edge commits i_bpm
//   o_step_tick  out  1   one-cycle pulse per sequencer step
//   o_beat_tick  out  1   pulse with o_step_tick on beat boundaries
//   o_step_idx   out  4   current step 0..15
//   o_cur_bpm    out 10   clamped tempo currently applied
//   o_busy       out  1   high while a period division is in progress
// ============================================================================
module step_clock_gen #(
  parameter int CLK_FREQ       = 50000000,
  parameter int STEPS_PER_BEAT = 4,
  parameter int BPM_DEFAULT    = 120
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic [9:0] i_bpm,
  input  logic       i_set,
  output logic       o_step_tick,
  output logic       o_beat_tick,
  output logic [3:0] o_step_idx,
  output logic [9:0] o_cur_bpm,
  output logic       o_busy
);

  // Dividend is cycles per minute; computed 64-bit wide so the default
  // 50 MHz * 60 does not overflow a signed 32-bit integer.
  localparam logic [63:0] c_dividend_wide  = 64'(CLK_FREQ) * 64'd60;
  localparam logic [31:0] c_dividend       = c_dividend_wide[31:0];
  localparam logic [63:0] c_period_wide    = c_dividend_wide / 64'(BPM_DEFAULT * STEPS_PER_BEAT);
  localparam logic [31:0] c_period_default = c_period_wide[31:0];
  localparam logic [9:0]  c_bpm_default    = 10'(BPM_DEFAULT);
  localparam logic [9:0]  c_bpm_min        = 10'd30;
  localparam logic [9:0]  c_bpm_max        = 10'd300;
  localparam logic [11:0] c_spb            = 12'(STEPS_PER_BEAT);
  // STEPS_PER_BEAT is a power of two, so "mod" reduces to a mask.
  localparam logic [3:0]  c_beat_mask      = 4'(STEPS_PER_BEAT - 1);
  localparam logic [4:0]  c_last_iter      = 5'd31;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_div_load;
  logic        w_div_done;

  logic        r_set_d;
  logic        w_commit;
  logic [9:0]  w_bc;
  logic [11:0] w_divisor;

  logic [4:0]  r_iter;
  logic [31:0] r_quo;
  logic [11:0] r_rem;
  logic [11:0] r_div;
  logic [9:0]  r_bc;
  logic [31:0] r_period;
  logic [9:0]  r_cur_bpm;
  logic        r_busy;

  logic [12:0] w_rem_shift;
  logic [12:0] w_rem_diff;
  logic        w_rem_ge;
  logic [11:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic        w_unused_diff_msb;

  logic [31:0] r_cnt;
  logic [3:0]  r_step_idx;
  logic        r_step_tick;
  logic        r_beat_tick;
  logic        w_terminal;
  logic [3:0]  w_idx_next;

  // --------------------------------------------------------------------------
  // Commit detection and tempo clamp. A zero BPM is not a commit at all.
  // --------------------------------------------------------------------------
  assign w_commit = i_set & ~r_set_d & (i_bpm != 10'd0);

  always_comb begin
    w_bc = i_bpm;
    if (i_bpm < c_bpm_min) begin
      w_bc = c_bpm_min;
    end else if (i_bpm > c_bpm_max) begin
      w_bc = c_bpm_max;
    end
  end

  // Max 300 * 8 = 2400, fits in 12 bits.
  assign w_divisor = 12'(w_bc) * c_spb;

  // --------------------------------------------------------------------------
  // Restoring divider step: shift the next dividend bit (held in the top of
  // the quotient register) into the remainder, subtract when it fits.
  // The remainder stays below the divisor, so 12 bits suffice.
  // --------------------------------------------------------------------------
  assign w_rem_shift       = {r_rem, r_quo[31]};
  assign w_rem_ge          = (w_rem_shift >= {1'b0, r_div});
  assign w_rem_diff        = w_rem_shift - {1'b0, r_div};
  assign w_rem_next        = w_rem_ge ? w_rem_diff[11:0] : w_rem_shift[11:0];
  assign w_quo_next        = {r_quo[30:0], w_rem_ge};
  assign w_unused_diff_msb = w_rem_diff[12];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state. A commit during DIV restarts the division and takes
  // priority over finishing the one in flight.
  always_comb begin
    w_state_next = r_state;
    w_div_load   = 1'b0;
    w_div_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_commit) begin
          w_state_next = S_DIV;
          w_div_load   = 1'b1;
        end
      end
      S_DIV: begin
        if (w_commit) begin
          w_div_load = 1'b1;
        end else if (r_iter == c_last_iter) begin
          w_state_next = S_IDLE;
          w_div_done   = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Divider datapath, tempo and period registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // set_d starts high so a set line held at 1 through reset is not
      // mistaken for a fresh commit.
      r_set_d   <= 1'b1;
      r_iter    <= 5'd0;
      r_quo     <= 32'd0;
      r_rem     <= 12'd0;
      r_div     <= 12'd0;
      r_bc      <= c_bpm_default;
      r_period  <= c_period_default;
      r_cur_bpm <= c_bpm_default;
      r_busy    <= 1'b0;
    end else begin
      r_set_d <= i_set;
      r_busy  <= (w_state_next == S_DIV);
      if (w_div_load) begin
        r_iter <= 5'd0;
        r_quo  <= c_dividend;
        r_rem  <= 12'd0;
        r_div  <= w_divisor;
        r_bc   <= w_bc;
      end else if (r_state == S_DIV) begin
        r_iter <= r_iter + 5'd1;
        r_quo  <= w_quo_next;
        r_rem  <= w_rem_next;
      end
      // Final quotient bit is produced on this same edge, so take the
      // combinational next value rather than r_quo.
      if (w_div_done) begin
        r_period  <= w_quo_next;
        r_cur_bpm <= r_bc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Step counter. Terminal is cnt >= period-1, written as cnt+1 >= period
  // so a shrunken period fires on the next edge and a zero period cannot
  // underflow the compare.
  // --------------------------------------------------------------------------
  assign w_terminal = ({1'b0, r_cnt} + 33'd1) >= {1'b0, r_period};
  assign w_idx_next = r_step_idx + 4'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_cnt       <= 32'd0;
      r_step_idx  <= 4'd0;
      r_step_tick <= 1'b0;
      r_beat_tick <= 1'b0;
    end else if (w_terminal) begin
      r_cnt       <= 32'd0;
      r_step_idx  <= w_idx_next;
      r_step_tick <= 1'b1;
      r_beat_tick <= ((w_idx_next & c_beat_mask) == 4'd0);
    end else begin
      r_cnt       <= r_cnt + 32'd1;
      r_step_tick <= 1'b0;
      r_beat_tick <= 1'b0;
    end
  end

  assign o_step_tick = r_step_tick;
  assign o_beat_tick = r_beat_tick;
  assign o_step_idx  = r_step_idx;
  assign o_cur_bpm   = r_cur_bpm;
  assign o_busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_step_clock_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_clock_gen
// Description : Self-checking bench for step_clock_gen at CLK_FREQ=1200,
//               STEPS_PER_BEAT=4 (period = 18000 / clamped BPM).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_clock_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [9:0] bpm;
  logic       set;
  logic       step_tick;
  logic       beat_tick;
  logic [3:0] step_idx;
  logic [9:0] cur_bpm;
  logic       busy;

  step_clock_gen #(
    .CLK_FREQ      (1200),
    .STEPS_PER_BEAT(4),
    .BPM_DEFAULT   (120)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_enable   (enable),
    .i_bpm      (bpm),
    .i_set      (set),
    .o_step_tick(step_tick),
    .o_beat_tick(beat_tick),
    .o_step_idx (step_idx),
    .o_cur_bpm  (cur_bpm),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] bpm;
    int         exp_bpm;
    int         exp_period;
    int         exp_busy;
  } vec_t;

  typedef struct {
    int cur_bpm;
    int period;
  } sb_t;

  vec_t vecs[9];
  sb_t  sb_q[$];
  sb_t  e;

  int n_vec      = 0;
  int n_err      = 0;
  int busy_run   = 0;
  int last_run   = 0;
  int tick_count = 0;
  bit busy_seen  = 1'b0;
  int n;
  int tc0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock; inputs are driven and outputs sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (step_tick === 1'b1) tick_count++;
    if (busy === 1'b1) begin
      busy_run++;
      busy_seen = 1'b1;
    end else if (busy_run > 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  endtask

  // Returns the number of edges until step_tick is seen high.
  task automatic wait_tick(input int budget, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (step_tick !== 1'b1 && cycles < budget);
    if (step_tick !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL tick_timeout: got no step_tick in %0d cycles, expected one", budget);
    end
  endtask

  task automatic wait_busy_fall(input int budget);
    int k;
    k = 0;
    while (busy === 1'b1 && k < budget) begin
      step();
      k++;
    end
    if (busy !== 1'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL busy_timeout: got busy=%b after %0d cycles, expected 0", busy, budget);
    end
  endtask

  // Guarantees a 0->1 edge on set; returns just after the commit edge.
  task automatic commit(input logic [9:0] b);
    set = 1'b0;
    step();
    last_run = 0;
    bpm = b;
    set = 1'b1;
    step();
    set = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no summary by time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{10'd300, 300,  60, 32};
    vecs[1] = '{10'd999, 300,  60, 32};
    vecs[2] = '{10'd10,   30, 600, 32};
    vecs[3] = '{10'd200, 200,  90, 32};
    vecs[4] = '{10'd0,   200,  90,  0};
    vecs[5] = '{10'd29,   30, 600, 32};
    vecs[6] = '{10'd301, 300,  60, 32};
    vecs[7] = '{10'd30,   30, 600, 32};
    vecs[8] = '{10'd120, 120, 150, 32};

    // ---------------- reset state, set held high ----------------
    rst    = 1'b1;
    enable = 1'b0;
    set    = 1'b1;
    bpm    = 10'd0;
    repeat (3) step();
    check("rst_step_tick", int'(step_tick), 0);
    check("rst_beat_tick", int'(beat_tick), 0);
    check("rst_step_idx",  int'(step_idx), 0);
    check("rst_cur_bpm",   int'(cur_bpm), 120);
    check("rst_busy",      int'(busy), 0);
    busy_seen = 1'b0;

    // ---------------- default tempo, 16 steps with wrap ----------------
    rst    = 1'b0;
    enable = 1'b1;
    wait_tick(400, n);
    check("first_tick_latency", n, 150);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) begin
        wait_tick(400, n);
        check("tick_spacing_150", n, 150);
      end
      check("step_idx_seq", int'(step_idx), k % 16);
      check("beat_tick_seq", int'(beat_tick), (k % 4 == 0) ? 1 : 0);
    end
    step();
    check("tick_one_cycle", int'(step_tick), 0);
    check("busy_with_set_held", int'(busy_seen), 0);

    // ---------------- table: commits, clamps, ignored zero ----------------
    for (int i = 0; i < 9; i++) begin
      sb_q.push_back('{vecs[i].exp_bpm, vecs[i].exp_period});
      commit(vecs[i].bpm);
      e = sb_q.pop_front();
      if (vecs[i].exp_busy == 0) begin
        check("zero_bpm_busy", int'(busy), 0);
        repeat (3) step();
        check("zero_bpm_busy_later", last_run + busy_run, 0);
        check("zero_bpm_cur_bpm", int'(cur_bpm), e.cur_bpm);
      end else begin
        wait_busy_fall(100);
        check("busy_len", last_run, vecs[i].exp_busy);
        check("cur_bpm", int'(cur_bpm), e.cur_bpm);
      end
      wait_tick(1400, n);
      wait_tick(1400, n);
      check("period", n, e.period);
    end

    // ---------------- restart: commit 60 then 200 ten cycles later ----------------
    commit(10'd60);
    repeat (9) step();
    bpm = 10'd200;
    set = 1'b1;
    step();
    set = 1'b0;
    wait_busy_fall(100);
    check("restart_busy_len", last_run, 42);
    check("restart_cur_bpm", int'(cur_bpm), 200);
    wait_tick(1400, n);
    wait_tick(1400, n);
    check("restart_period", n, 90);

    // ---------------- period shrink: 120 BPM, cnt=100, commit 300 ----------------
    commit(10'd120);
    wait_busy_fall(100);
    check("shrink_setup_bpm", int'(cur_bpm), 120);
    wait_tick(400, n);
    repeat (99) step();
    tc0 = tick_count;
    commit(10'd300);
    wait_busy_fall(100);
    check("shrink_no_tick_in_div", tick_count - tc0, 0);
    check("shrink_cur_bpm", int'(cur_bpm), 300);
    step();
    check("shrink_tick_next_edge", int'(step_tick), 1);

    // ---------------- enable drop, divider runs while stopped ----------------
    repeat (20) step();
    enable = 1'b0;
    step();
    check("stop_step_idx", int'(step_idx), 0);
    check("stop_step_tick", int'(step_tick), 0);
    tc0 = tick_count;
    repeat (100) step();
    check("stop_no_ticks", tick_count - tc0, 0);
    commit(10'd150);
    wait_busy_fall(100);
    check("stop_div_busy_len", last_run, 32);
    check("stop_div_cur_bpm", int'(cur_bpm), 150);
    enable = 1'b1;
    wait_tick(400, n);
    check("restart_first_tick", n, 120);
    check("restart_step_idx", int'(step_idx), 1);

    // ---------------- reset mid-division ----------------
    commit(10'd60);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("middiv_rst_busy", int'(busy), 0);
    check("middiv_rst_cur_bpm", int'(cur_bpm), 120);
    check("middiv_rst_step_idx", int'(step_idx), 0);
    wait_tick(400, n);
    check("middiv_rst_period", n, 150);
    check("middiv_rst_bpm_kept", int'(cur_bpm), 120);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/step_clock_gen.md
STEP_CLOCK_GEN -- requirements
Module: step_clock_gen

Interface
REQ-001 Parameter CLK_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter STEPS_PER_BEAT, default 4: steps per quarter-note beat, legal values 1, 2, 4 or 8.
REQ-003 Parameter BPM_DEFAULT, default 120: tempo in effect after reset, legal range 30..300.
REQ-004 Clock  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Enable  input  1  run (1) / stop (0) of the step playhead.
REQ-007 BPM  input  10  requested tempo from the BPM entry FSM, 0..999.
REQ-008 set  input  1  tempo-committed flag from the BPM entry FSM; a 0->1 transition commits BPM.
REQ-009 step_tick  output  1  one-cycle pulse per sequencer step.
REQ-010 beat_tick  output  1  one-cycle pulse coincident with step_tick on beat boundaries.
REQ-011 step_idx  output  4  current step 0..15.
REQ-012 cur_bpm  output  10  clamped tempo currently applied.
REQ-013 busy  output  1  high while a period division is in progress.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 Rising-edge detect: set_d SHALL be a register of set; a commit SHALL occur when set=1 and set_d=0.
REQ-016 On commit with BPM=0: ignored; no state change.
REQ-017 On commit with BPM nonzero: clamp to 30 if BPM<30, to 300 if BPM>300, else use BPM; the result is Bc.
REQ-018 Period: period = floor(CLK_FREQ*60 / (Bc*STEPS_PER_BEAT)), 32-bit unsigned; divisor 12 bits.
REQ-019 Division SHALL be sequential: a restoring divider, 1 quotient bit per cycle, with no combinational divide operator.
REQ-020 FSM states: IDLE and DIV. A commit in IDLE enters DIV. DIV runs exactly 32 cycles, then returns to IDLE.
REQ-021 busy=1 exactly while in DIV, i.e. for 32 cycles starting the edge after the commit is sampled.
REQ-022 On the edge leaving DIV: period_reg <= quotient and cur_bpm <= Bc, both in the same edge.
REQ-023 A commit while in DIV SHALL abort and restart the division with the new Bc; busy stays high.
REQ-024 The step counter SHALL use the old period_reg throughout DIV; ticking is never interrupted by a division.
REQ-025 Counter cnt (32 bits): while Enable=1, terminal when cnt >= period_reg-1.
REQ-026 At terminal: next edge sets cnt <= 0, step_idx <= step_idx+1 (15 wraps to 0), step_tick <= 1.
REQ-027 Not at terminal: cnt increments and step_tick <= 0.
REQ-028 beat_tick <= 1 on the same edge as step_tick when (new step_idx mod STEPS_PER_BEAT)=0, else 0.
REQ-029 Period shrink: if a new period_reg makes cnt >= period_reg-1, a tick SHALL occur on the next edge.
REQ-030 While Enable=0: cnt <= 0, step_idx <= 0, step_tick <= 0, beat_tick <= 0. The divider SHALL still operate.
REQ-031 Enable 0->1: the first step_tick SHALL occur exactly period_reg cycles after the first cycle Enable is sampled high, with step_idx=1.
REQ-032 Step ticks SHALL be spaced exactly period_reg cycles while the period is unchanged.

Reset
REQ-033 Reset=1 at an edge SHALL set: cnt=0, step_idx=0, step_tick=0, beat_tick=0, busy=0, state=IDLE.
REQ-034 Reset=1 at an edge SHALL also set: cur_bpm=BPM_DEFAULT, period_reg=CLK_FREQ*60/(BPM_DEFAULT*STEPS_PER_BEAT) (elaboration constant).
REQ-035 Reset SHALL set set_d=1, so that set held at 1 after reset never produces a commit.
REQ-036 Reset asserted mid-division SHALL discard the division; period_reg takes its reset value.
REQ-037 Reset SHALL have priority over Enable, commits and ticks.

Verification (CLK_FREQ=1200, STEPS_PER_BEAT=4, so period=18000/Bc)
REQ-038 Reset, then Enable=1 with set held at 1 -> busy never rises; ticks every 150 cycles; step_idx 1,2,3,...; beat_tick at step_idx 4, 8, 12, 0.
REQ-039 set pulse 0->1 with BPM=300 -> busy high 32 cycles; cur_bpm=300; ticks then every 60 cycles; old 150-cycle spacing kept during busy.
REQ-040 Commit with BPM=999 -> cur_bpm=300, period 60. Commit with BPM=10 -> cur_bpm=30, period 600. Commit with BPM=0 -> busy stays 0, no change.
REQ-041 Commit BPM=60, then commit BPM=200 ten cycles later -> busy continuous for 42 cycles; cur_bpm=200, period 90.
REQ-042 At 120 BPM with cnt=100, commit 300 -> at busy fall, cnt >= 59, so step_tick on the next edge.
REQ-043 Wrap and stop checks -> after 16 ticks, step_idx=0 with beat_tick=1. Enable dropped mid-count -> step_idx=0 next edge, no ticks. Reset mid-DIV -> busy=0, cur_bpm=120.
